// File: rtl/ikari_cen_pkg.sv
// Shared defaults and control types for the ikari clock-enable bank.
// Increment constants assume ACC_W=16 and a 53.6 MHz system clock.
package ikari_cen_pkg;

   localparam int unsigned CEN_NCH_DEF   = 32'd4;
   localparam int unsigned CEN_ACC_W_DEF = 32'd16;

   localparam logic [15:0] CEN_INC_13M4 = 16'd16384;
   localparam logic [15:0] CEN_INC_6M7  = 16'd8192;
   localparam logic [15:0] CEN_INC_3M35 = 16'd4096;
   localparam logic [15:0] CEN_INC_4M0  = 16'd4891;

   // Per-cycle command shared by every channel; load wins over advance.
   typedef struct packed {
      logic load;
      logic adv;
   } cen_ctl_t;

endpackage

// File: rtl/ikari_cen_acc.sv
// One clock-enable channel: two phase accumulators half a turn apart,
// their registered carries, and a divided-clock toggle.
module ikari_cen_acc
   import ikari_cen_pkg::*;
#(
   parameter int unsigned ACC_W = CEN_ACC_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  cen_ctl_t         i_ctl,
   input  logic [ACC_W-1:0] i_inc,
   input  logic [ACC_W-1:0] i_phase,
   output logic             o_cen,
   output logic             o_cenb,
   output logic             o_clk
);

   localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0] a_q, a_d, b_q, b_d, inc_q, inc_d;
   logic             cen_q, cen_d, cenb_q, cenb_d, clk_q, clk_d;
   logic [ACC_W:0]   sum_a_s, sum_b_s;

   assign sum_a_s = {1'b0, a_q} + {1'b0, inc_q};
   assign sum_b_s = {1'b0, b_q} + {1'b0, inc_q};

   // Next state: load restarts both phases, advance accumulates, otherwise hold.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      inc_d  = inc_q;
      cen_d  = 1'b0;
      cenb_d = 1'b0;
      clk_d  = clk_q;
      if (i_ctl.load) begin
         inc_d = i_inc;
         a_d   = i_phase;
         b_d   = i_phase + HALF;
         clk_d = 1'b0;
      end else if (i_ctl.adv) begin
         a_d    = sum_a_s[ACC_W-1:0];
         b_d    = sum_b_s[ACC_W-1:0];
         cen_d  = sum_a_s[ACC_W];
         cenb_d = sum_b_s[ACC_W];
         // A coincident A and B carry yields a single toggle.
         clk_d  = clk_q ^ (sum_a_s[ACC_W] | sum_b_s[ACC_W]);
      end else begin
         clk_d = clk_q;
      end
   end

   // Channel state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q    <= {ACC_W{1'b0}};
         b_q    <= HALF;
         inc_q  <= {ACC_W{1'b0}};
         cen_q  <= 1'b0;
         cenb_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         inc_q  <= inc_d;
         cen_q  <= cen_d;
         cenb_q <= cenb_d;
         clk_q  <= clk_d;
      end
   end

   assign o_cen  = cen_q;
   assign o_cenb = cenb_q;
   assign o_clk  = clk_q;

endmodule

// File: rtl/ikari_cen_bank.sv
// Bank of NCH independent fractional clock-enable generators sharing
// one load strobe and one pause request.
module ikari_cen_bank
   import ikari_cen_pkg::*;
#(
   parameter int unsigned NCH   = CEN_NCH_DEF,
   parameter int unsigned ACC_W = CEN_ACC_W_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NCH*ACC_W-1:0] i_inc,
   input  logic [NCH*ACC_W-1:0] i_phase,
   input  logic                 i_load,
   input  logic                 i_pause,
   output logic                 o_load_ack,
   output logic [NCH-1:0]       o_cen,
   output logic [NCH-1:0]       o_cenb,
   output logic [NCH-1:0]       o_clk
);

   cen_ctl_t ctl_s;
   logic     load_ack_q, load_ack_d;

   // Load takes priority; pause only blocks accumulation.
   always_comb begin
      ctl_s.load = i_load;
      ctl_s.adv  = 1'b0;
      load_ack_d = i_load;
      if (i_load) begin
         ctl_s.adv = 1'b0;
      end else begin
         ctl_s.adv = ~i_pause;
      end
   end

   // Load acknowledge register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         load_ack_q <= 1'b0;
      end else begin
         load_ack_q <= load_ack_d;
      end
   end

   assign o_load_ack = load_ack_q;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      ikari_cen_acc #(
         .ACC_W (ACC_W)
      ) u_acc (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_ctl   (ctl_s),
         .i_inc   (i_inc[k*ACC_W +: ACC_W]),
         .i_phase (i_phase[k*ACC_W +: ACC_W]),
         .o_cen   (o_cen[k]),
         .o_cenb  (o_cenb[k]),
         .o_clk   (o_clk[k])
      );
   end

endmodule

// File: tb/tb_ikari_cen_bank.sv
// Self-checking bench: a 16-bit, 4-channel bank checked against a phase
// model, and a 4-bit, 2-channel bank checked with hand-derived patterns.
module tb_ikari_cen_bank;
   import ikari_cen_pkg::*;

   localparam int N16 = 4;
   localparam int N4  = 2;
   localparam int unsigned MOD16  = 32'd65536;
   localparam int unsigned HALF16 = 32'd32768;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            ld16 = 1'b0, pz16 = 1'b0, ack16;
   logic [63:0]     inc16 = 64'd0, ph16 = 64'd0;
   logic [3:0]      cen16, cenb16, oclk16;
   logic            ld4 = 1'b0, pz4 = 1'b0, ack4;
   logic [7:0]      inc4 = 8'd0, ph4 = 8'd0;
   logic [1:0]      cen4, cenb4, oclk4;

   int total = 0;
   int bad   = 0;

   ikari_cen_bank #(.NCH(N16), .ACC_W(16)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc16), .i_phase(ph16),
      .i_load(ld16), .i_pause(pz16), .o_load_ack(ack16),
      .o_cen(cen16), .o_cenb(cenb16), .o_clk(oclk16)
   );

   ikari_cen_bank #(.NCH(N4), .ACC_W(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc4), .i_phase(ph4),
      .i_load(ld4), .i_pause(pz4), .o_load_ack(ack4),
      .o_cen(cen4), .o_cenb(cenb4), .o_clk(oclk4)
   );

   // Phase model of the 16-bit bank: integer phases that wrap at 2^16.
   int unsigned m_a[N16], m_b[N16], m_inc[N16];
   logic        m_cen[N16], m_cenb[N16], m_clk[N16];
   logic        m_ack;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ack <= 1'b0;
         for (int k = 0; k < N16; k++) begin
            m_a[k] <= 0; m_b[k] <= HALF16; m_inc[k] <= 0;
            m_cen[k] <= 1'b0; m_cenb[k] <= 1'b0; m_clk[k] <= 1'b0;
         end
      end else begin
         m_ack <= ld16;
         for (int k = 0; k < N16; k++) begin
            if (ld16) begin
               m_inc[k]  <= int'(inc16[k*16 +: 16]);
               m_a[k]    <= int'(ph16[k*16 +: 16]);
               m_b[k]    <= (int'(ph16[k*16 +: 16]) + HALF16) % MOD16;
               m_cen[k]  <= 1'b0; m_cenb[k] <= 1'b0; m_clk[k] <= 1'b0;
            end else if (!pz16) begin
               m_a[k]    <= (m_a[k] + m_inc[k]) % MOD16;
               m_b[k]    <= (m_b[k] + m_inc[k]) % MOD16;
               m_cen[k]  <= (m_a[k] + m_inc[k]) >= MOD16;
               m_cenb[k] <= (m_b[k] + m_inc[k]) >= MOD16;
               if (((m_a[k] + m_inc[k]) >= MOD16) || ((m_b[k] + m_inc[k]) >= MOD16))
                  m_clk[k] <= ~m_clk[k];
            end else begin
               m_cen[k] <= 1'b0; m_cenb[k] <= 1'b0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] pick_inc();
      case ($urandom_range(0, 6))
         0: return 16'd0;
         1: return CEN_INC_13M4;
         2: return CEN_INC_6M7;
         3: return CEN_INC_3M35;
         4: return CEN_INC_4M0;
         5: return 16'(32'd32768 + $urandom_range(0, 32767));
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; ld16 = 1'b1; inc16 = {4{CEN_INC_13M4}}; ld4 = 1'b1; inc4 = 8'h44;
      repeat (3) cyc();
      total++; if (ack16 !== 1'b0)  begin bad++; $display("FAIL rst_ack16 got=%b want=0", ack16); end
      total++; if (cen16 !== 4'h0)  begin bad++; $display("FAIL rst_cen16 got=%b want=0000", cen16); end
      total++; if (cenb16 !== 4'h0) begin bad++; $display("FAIL rst_cenb16 got=%b want=0000", cenb16); end
      total++; if (oclk16 !== 4'h0) begin bad++; $display("FAIL rst_clk16 got=%b want=0000", oclk16); end
      total++; if (ack4 !== 1'b0)   begin bad++; $display("FAIL rst_ack4 got=%b want=0", ack4); end
      total++; if ({cen4, cenb4, oclk4} !== 6'd0) begin bad++; $display("FAIL rst_out4 got=%b want=000000", {cen4, cenb4, oclk4}); end
      ld16 = 1'b0; ld4 = 1'b0; rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         cyc();
         total++; if ({ack16, cen16, cenb16, oclk16} !== 13'd0) begin bad++; $display("FAIL idle16 t=%0d got=%b want=0", t, {ack16, cen16, cenb16, oclk16}); end
         total++; if ({ack4, cen4, cenb4, oclk4} !== 7'd0) begin bad++; $display("FAIL idle4 t=%0d got=%b want=0", t, {ack4, cen4, cenb4, oclk4}); end
      end
   endtask

   task automatic test_phase_offset();
      logic [1:0] e_c, e_cb, e_k;
      inc4 = {4'd0, 4'd4}; ph4 = {4'd7, 4'd4}; ld4 = 1'b1;
      cyc();
      total++; if (ack4 !== 1'b1) begin bad++; $display("FAIL po_ack got=%b want=1", ack4); end
      total++; if ({cen4, cenb4, oclk4} !== 6'd0) begin bad++; $display("FAIL po_clear got=%b want=000000", {cen4, cenb4, oclk4}); end
      ld4 = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         cyc();
         e_c  = {1'b0, (t % 4) == 3};
         e_cb = {1'b0, (t % 4) == 1};
         e_k  = {1'b0, 1'(((t + 1) / 2) % 2)};
         total++; if (cen4 !== e_c)   begin bad++; $display("FAIL po_cen t=%0d got=%b want=%b", t, cen4, e_c); end
         total++; if (cenb4 !== e_cb) begin bad++; $display("FAIL po_cenb t=%0d got=%b want=%b", t, cenb4, e_cb); end
         total++; if (oclk4 !== e_k)  begin bad++; $display("FAIL po_clk t=%0d got=%b want=%b", t, oclk4, e_k); end
         total++; if (ack4 !== 1'b0)  begin bad++; $display("FAIL po_ack_low t=%0d got=%b want=0", t, ack4); end
      end
   endtask

   task automatic test_half_inc();
      logic e;
      inc4 = {4'd8, 4'd8}; ph4 = {4'd3, 4'd0}; ld4 = 1'b1;
      cyc();
      ld4 = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         cyc();
         e = 1'(t % 2);
         total++; if (cenb4 !== {e, e})   begin bad++; $display("FAIL hi_cenb t=%0d got=%b want=%b", t, cenb4, {e, e}); end
         total++; if (cen4 !== {~e, ~e})  begin bad++; $display("FAIL hi_cen t=%0d got=%b want=%b", t, cen4, {~e, ~e}); end
         total++; if (oclk4 !== {e, e})   begin bad++; $display("FAIL hi_clk t=%0d got=%b want=%b", t, oclk4, {e, e}); end
      end
   endtask

   task automatic test_load_hold();
      inc4 = {4'd8, 4'd8}; ph4 = 8'd0; ld4 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         cyc();
         total++; if (ack4 !== 1'b1) begin bad++; $display("FAIL lh_ack t=%0d got=%b want=1", t, ack4); end
         total++; if ({cen4, cenb4, oclk4} !== 6'd0) begin bad++; $display("FAIL lh_out t=%0d got=%b want=000000", t, {cen4, cenb4, oclk4}); end
      end
      ld4 = 1'b0;
      cyc();
      total++; if ({cen4, cenb4} !== 4'b0011) begin bad++; $display("FAIL lh_first got=%b want=0011", {cen4, cenb4}); end
      cyc();
      total++; if ({cen4, cenb4} !== 4'b1100) begin bad++; $display("FAIL lh_second got=%b want=1100", {cen4, cenb4}); end
   endtask

   task automatic test_load_pause();
      inc4 = {4'd4, 4'd4}; ph4 = {4'd4, 4'd4}; ld4 = 1'b1; pz4 = 1'b1;
      cyc();
      total++; if (ack4 !== 1'b1) begin bad++; $display("FAIL lp_ack got=%b want=1", ack4); end
      ld4 = 1'b0;
      for (int t = 0; t < 6; t++) begin
         cyc();
         total++; if ({ack4, cen4, cenb4, oclk4} !== 7'd0) begin bad++; $display("FAIL lp_frozen t=%0d got=%b want=0", t, {ack4, cen4, cenb4, oclk4}); end
      end
      pz4 = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         cyc();
         total++; if (cenb4 !== (t == 1 ? 2'b11 : 2'b00)) begin bad++; $display("FAIL lp_cenb t=%0d got=%b", t, cenb4); end
         total++; if (cen4 !== (t == 3 ? 2'b11 : 2'b00))  begin bad++; $display("FAIL lp_cen t=%0d got=%b", t, cen4); end
      end
   endtask

   task automatic test_pause_count();
      int unsigned cnt_a[N16], cnt_b[N16], ea, eb, ph;
      logic [3:0] clk_hold;
      for (int k = 0; k < N16; k++) begin
         ph16[k*16 +: 16] = 16'($urandom); cnt_a[k] = 0; cnt_b[k] = 0;
      end
      inc16 = {4{CEN_INC_4M0}}; ld16 = 1'b1; pz16 = 1'b0;
      cyc();
      ld16 = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         if (t == 400) begin
            pz16 = 1'b1; clk_hold = oclk16;
            for (int q = 0; q < 10; q++) begin
               cyc();
               total++; if ((cen16 | cenb16) !== 4'h0) begin bad++; $display("FAIL pc_quiet q=%0d got=%b want=0000", q, cen16 | cenb16); end
               total++; if (oclk16 !== clk_hold) begin bad++; $display("FAIL pc_clk_hold q=%0d got=%b want=%b", q, oclk16, clk_hold); end
            end
            pz16 = 1'b0;
         end
         cyc();
         for (int k = 0; k < N16; k++) begin
            cnt_a[k] += int'(cen16[k]); cnt_b[k] += int'(cenb16[k]);
         end
      end
      for (int k = 0; k < N16; k++) begin
         ph = int'(ph16[k*16 +: 16]);
         ea = (ph + 1000 * 4891) / MOD16;
         eb = (((ph + HALF16) % MOD16) + 1000 * 4891) / MOD16;
         total++; if (cnt_a[k] != ea) begin bad++; $display("FAIL pc_count_cen ch=%0d got=%0d want=%0d", k, cnt_a[k], ea); end
         total++; if (cnt_b[k] != eb) begin bad++; $display("FAIL pc_count_cenb ch=%0d got=%0d want=%0d", k, cnt_b[k], eb); end
      end
   endtask

   task automatic test_long();
      int unsigned cnt_a[N16], cnt_b[N16];
      inc16 = {CEN_INC_3M35, CEN_INC_6M7, CEN_INC_13M4, CEN_INC_4M0};
      for (int k = 0; k < N16; k++) begin
         ph16[k*16 +: 16] = 16'($urandom); cnt_a[k] = 0; cnt_b[k] = 0;
      end
      ld16 = 1'b1;
      cyc();
      ld16 = 1'b0;
      for (int t = 0; t < 65536; t++) begin
         cyc();
         for (int k = 0; k < N16; k++) begin
            cnt_a[k] += int'(cen16[k]); cnt_b[k] += int'(cenb16[k]);
         end
      end
      for (int k = 0; k < N16; k++) begin
         total++; if (cnt_a[k] != int'(inc16[k*16 +: 16])) begin bad++; $display("FAIL long_cen ch=%0d got=%0d want=%0d", k, cnt_a[k], inc16[k*16 +: 16]); end
         total++; if (cnt_b[k] != int'(inc16[k*16 +: 16])) begin bad++; $display("FAIL long_cenb ch=%0d got=%0d want=%0d", k, cnt_b[k], inc16[k*16 +: 16]); end
      end
   endtask

   task automatic test_rand();
      logic [3:0] ec, ecb, ek;
      pz16 = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         ld16 = (i == 0) || ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 9) == 0) pz16 = ~pz16;
         if (ld16) begin
            for (int k = 0; k < N16; k++) begin
               inc16[k*16 +: 16] = pick_inc(); ph16[k*16 +: 16] = 16'($urandom);
            end
         end
         cyc();
         for (int k = 0; k < N16; k++) begin
            ec[k] = m_cen[k]; ecb[k] = m_cenb[k]; ek[k] = m_clk[k];
         end
         total++; if (cen16 !== ec)   begin bad++; $display("FAIL rand_cen i=%0d got=%b want=%b", i, cen16, ec); end
         total++; if (cenb16 !== ecb) begin bad++; $display("FAIL rand_cenb i=%0d got=%b want=%b", i, cenb16, ecb); end
         total++; if (oclk16 !== ek)  begin bad++; $display("FAIL rand_clk i=%0d got=%b want=%b", i, oclk16, ek); end
         total++; if (ack16 !== m_ack) begin bad++; $display("FAIL rand_ack i=%0d got=%b want=%b", i, ack16, m_ack); end
      end
      ld16 = 1'b0; pz16 = 1'b0;
   endtask

   task automatic test_async_reset();
      inc16 = {4{CEN_INC_13M4}}; ph16 = 64'd0; ld16 = 1'b1;
      cyc();
      ld16 = 1'b0;
      repeat (21) cyc();
      @(posedge clk);
      #3;
      rst_n = 1'b0; ld16 = 1'b1;
      #1;
      total++; if ({ack16, cen16, cenb16, oclk16} !== 13'd0) begin bad++; $display("FAIL ar_async16 got=%b want=0", {ack16, cen16, cenb16, oclk16}); end
      total++; if ({ack4, cen4, cenb4, oclk4} !== 7'd0) begin bad++; $display("FAIL ar_async4 got=%b want=0", {ack4, cen4, cenb4, oclk4}); end
      repeat (3) cyc();
      ld16 = 1'b0; rst_n = 1'b1;
      for (int t = 0; t < 40; t++) begin
         cyc();
         total++; if ({ack16, cen16, cenb16, oclk16} !== 13'd0) begin bad++; $display("FAIL ar_idle t=%0d got=%b want=0", t, {ack16, cen16, cenb16, oclk16}); end
      end
      ld16 = 1'b1;
      cyc();
      ld16 = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         cyc();
         total++; if (cenb16 !== (t == 2 ? 4'hF : 4'h0)) begin bad++; $display("FAIL ar_cenb t=%0d got=%b", t, cenb16); end
         total++; if (cen16 !== (t == 4 ? 4'hF : 4'h0))  begin bad++; $display("FAIL ar_cen t=%0d got=%b", t, cen16); end
      end
   endtask

   initial begin
      test_reset();
      test_phase_offset();
      test_half_inc();
      test_load_hold();
      test_load_pause();
      test_pause_count();
      test_long();
      test_rand();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
